// File: rtl/vga_char_timing.sv
// vga_char_timing
//   Parametrised VGA timing and text-mode character-cell generator. The
//   address stage generates the pixel coordinate, the character cell and the
//   position inside the cell for the current pixel. Sync, valid and colour are
//   delayed by PIPE_LAT enabled cycles plus one output register, so that they
//   line up with a char-RAM/font-ROM fetch path that returns vga_data.
//
// Ports
//   pclk        pixel clock, rising edge
//   reset_n     asynchronous active-low reset
//   pclk_en     advance enable; all state holds while low
//   vga_data    {R,G,B} for the pixel addressed PIPE_LAT enabled cycles ago
//   h_addr/v_addr   active pixel coordinate (0 outside the active area)
//   h_char/v_char   character column/row
//   h_font/v_font   pixel/line inside the character cell
//   addr_valid  current address lies inside the active area
//   line_start  pulse on the first pixel of each line (0 while frozen)
//   frame_start pulse on pixel (0,0) (0 while frozen)
//   hsync/vsync delayed syncs
//   valid       delayed active flag
//   vga_r/g/b   colour, zero when not valid
module vga_char_timing #(
  parameter int H_ACTIVE  = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_ACTIVE  = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33,
  parameter int HSYNC_POL = 0,
  parameter int VSYNC_POL = 0,
  parameter int CHAR_W    = 9,
  parameter int CHAR_H    = 16,
  parameter int PIPE_LAT  = 2,
  parameter int ADDR_W    = 10
) (
  input  logic              pclk,
  input  logic              reset_n,
  input  logic              pclk_en,
  input  logic [11:0]       vga_data,
  output logic [ADDR_W-1:0] h_addr,
  output logic [ADDR_W-1:0] v_addr,
  output logic [6:0]        h_char,
  output logic [4:0]        v_char,
  output logic [3:0]        h_font,
  output logic [3:0]        v_font,
  output logic              addr_valid,
  output logic              line_start,
  output logic              frame_start,
  output logic              hsync,
  output logic              vsync,
  output logic              valid,
  output logic [3:0]        vga_r,
  output logic [3:0]        vga_g,
  output logic [3:0]        vga_b
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  // One spare bit so that the sync-end compare value always fits
  localparam int XW = $clog2(H_TOTAL + 1);
  localparam int YW = $clog2(V_TOTAL + 1);

  localparam logic [XW-1:0] X_LAST = XW'(H_TOTAL - 1);
  localparam logic [XW-1:0] X_ACT  = XW'(H_ACTIVE);
  localparam logic [XW-1:0] X_HS0  = XW'(H_ACTIVE + H_FP);
  localparam logic [XW-1:0] X_HS1  = XW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [YW-1:0] Y_LAST = YW'(V_TOTAL - 1);
  localparam logic [YW-1:0] Y_ACT  = YW'(V_ACTIVE);
  localparam logic [YW-1:0] Y_VS0  = YW'(V_ACTIVE + V_FP);
  localparam logic [YW-1:0] Y_VS1  = YW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [3:0]    HF_LAST = 4'(CHAR_W - 1);
  localparam logic [3:0]    VF_LAST = 4'(CHAR_H - 1);
  localparam logic          HS_ON = (HSYNC_POL != 0);
  localparam logic          VS_ON = (VSYNC_POL != 0);
  // {hsync, vsync, valid} with both syncs idle and no video
  localparam logic [2:0]    FLAGS_IDLE = {~HS_ON, ~VS_ON, 1'b0};

  logic [XW-1:0] x_cnt, x_nxt;
  logic [YW-1:0] y_cnt, y_nxt;
  logic [3:0]    hf_cnt, hf_nxt, vf_cnt, vf_nxt;
  logic [6:0]    hc_cnt, hc_nxt;
  logic [4:0]    vc_cnt, vc_nxt;
  logic          act_nxt;
  logic          line_start_q, frame_start_q;
  logic          hs_raw, vs_raw;
  logic [2:0]    flags_raw, flags_dly;

  // Character counters run alongside x/y and restart at every line/frame,
  // so a partial last cell never needs a divider to resolve.
  always_comb begin
    x_nxt  = x_cnt + 1'b1;
    y_nxt  = y_cnt;
    hf_nxt = hf_cnt + 1'b1;
    hc_nxt = hc_cnt;
    vf_nxt = vf_cnt;
    vc_nxt = vc_cnt;
    if (hf_cnt == HF_LAST) begin
      hf_nxt = '0;
      hc_nxt = hc_cnt + 1'b1;
    end
    if (x_cnt == X_LAST) begin
      x_nxt  = '0;
      hf_nxt = '0;
      hc_nxt = '0;
      y_nxt  = y_cnt + 1'b1;
      vf_nxt = vf_cnt + 1'b1;
      if (vf_cnt == VF_LAST) begin
        vf_nxt = '0;
        vc_nxt = vc_cnt + 1'b1;
      end
      if (y_cnt == Y_LAST) begin
        y_nxt  = '0;
        vf_nxt = '0;
        vc_nxt = '0;
      end
    end
    act_nxt = (x_nxt < X_ACT) && (y_nxt < Y_ACT);
  end

  always_ff @(posedge pclk or negedge reset_n) begin
    if (!reset_n) begin
      x_cnt         <= '0;
      y_cnt         <= '0;
      hf_cnt        <= '0;
      hc_cnt        <= '0;
      vf_cnt        <= '0;
      vc_cnt        <= '0;
      h_addr        <= '0;
      v_addr        <= '0;
      h_char        <= '0;
      v_char        <= '0;
      h_font        <= '0;
      v_font        <= '0;
      addr_valid    <= 1'b1;
      line_start_q  <= 1'b1;
      frame_start_q <= 1'b1;
    end else if (pclk_en) begin
      x_cnt         <= x_nxt;
      y_cnt         <= y_nxt;
      hf_cnt        <= hf_nxt;
      hc_cnt        <= hc_nxt;
      vf_cnt        <= vf_nxt;
      vc_cnt        <= vc_nxt;
      addr_valid    <= act_nxt;
      h_addr        <= act_nxt ? ADDR_W'(x_nxt) : '0;
      v_addr        <= act_nxt ? ADDR_W'(y_nxt) : '0;
      h_char        <= act_nxt ? hc_nxt : '0;
      v_char        <= act_nxt ? vc_nxt : '0;
      h_font        <= act_nxt ? hf_nxt : '0;
      v_font        <= act_nxt ? vf_nxt : '0;
      line_start_q  <= (x_nxt == '0);
      frame_start_q <= (x_nxt == '0) && (y_nxt == '0);
    end
  end

  // Pulses are suppressed while frozen so a stalled pixel is not counted twice
  assign line_start  = line_start_q & pclk_en;
  assign frame_start = frame_start_q & pclk_en;

  assign hs_raw    = ((x_cnt >= X_HS0) && (x_cnt < X_HS1)) ? HS_ON : ~HS_ON;
  assign vs_raw    = ((y_cnt >= Y_VS0) && (y_cnt < Y_VS1)) ? VS_ON : ~VS_ON;
  assign flags_raw = {hs_raw, vs_raw, addr_valid};

  generate
    if (PIPE_LAT == 0) begin : g_no_pipe
      assign flags_dly = flags_raw;
    end else begin : g_pipe
      logic [2:0] pipe_q [PIPE_LAT];
      always_ff @(posedge pclk or negedge reset_n) begin
        if (!reset_n) begin
          for (int i = 0; i < PIPE_LAT; i++) pipe_q[i] <= FLAGS_IDLE;
        end else if (pclk_en) begin
          pipe_q[0] <= flags_raw;
          for (int i = 1; i < PIPE_LAT; i++) pipe_q[i] <= pipe_q[i-1];
        end
      end
      assign flags_dly = pipe_q[PIPE_LAT-1];
    end
  endgenerate

  always_ff @(posedge pclk or negedge reset_n) begin
    if (!reset_n) begin
      hsync <= ~HS_ON;
      vsync <= ~VS_ON;
      valid <= 1'b0;
      vga_r <= '0;
      vga_g <= '0;
      vga_b <= '0;
    end else if (pclk_en) begin
      hsync <= flags_dly[2];
      vsync <= flags_dly[1];
      valid <= flags_dly[0];
      {vga_r, vga_g, vga_b} <= flags_dly[0] ? vga_data : 12'h000;
    end
  end

endmodule

// File: tb/tb_vga_char_timing.sv
// tb_vga_char_timing
//   Drives a reduced video mode with random enable/data and compares every
//   output each cycle against a position model: the DUT state after k enabled
//   edges since reset is pixel k mod frame, and delayed outputs belong to
//   pixel k-PIPE_LAT-1.
module tb_vga_char_timing;

  localparam int HA = 40, HF = 4, HS = 6, HB = 5;
  localparam int VA = 20, VF = 2, VS = 2, VB = 3;
  localparam int CW = 9, CH = 16, PL = 2, AW = 10;
  localparam bit HSP = 1'b0, VSP = 1'b1;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FRAME = HT * VT;

  logic          pclk = 1'b0;
  logic          reset_n = 1'b0;
  logic          pclk_en = 1'b1;
  logic [11:0]   vga_data = 12'h000;
  logic [AW-1:0] h_addr, v_addr;
  logic [6:0]    h_char;
  logic [4:0]    v_char;
  logic [3:0]    h_font, v_font;
  logic          addr_valid, line_start, frame_start, hsync, vsync, valid;
  logic [3:0]    vga_r, vga_g, vga_b;

  int          n_chk = 0;
  int          n_fail = 0;
  int          n = 0;
  logic [11:0] src = 12'h000;

  always #5 pclk = ~pclk;

  vga_char_timing #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .HSYNC_POL(int'(HSP)), .VSYNC_POL(int'(VSP)),
    .CHAR_W(CW), .CHAR_H(CH), .PIPE_LAT(PL), .ADDR_W(AW)
  ) dut (
    .pclk(pclk), .reset_n(reset_n), .pclk_en(pclk_en), .vga_data(vga_data),
    .h_addr(h_addr), .v_addr(v_addr), .h_char(h_char), .v_char(v_char),
    .h_font(h_font), .v_font(v_font), .addr_valid(addr_valid),
    .line_start(line_start), .frame_start(frame_start),
    .hsync(hsync), .vsync(vsync), .valid(valid),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (pixel count %0d, t=%0t)", tag, act, exp, n, $time);
    end
  endtask

  function automatic int px(input int k);
    return (k % FRAME) % HT;
  endfunction

  function automatic int py(input int k);
    return (k % FRAME) / HT;
  endfunction

  task automatic check_outputs();
    int  x, y, xd, yd;
    bit  act, ev;
    bit  ehs, evs;
    x   = px(n);
    y   = py(n);
    act = (x < HA) && (y < VA);
    chk("addr_valid", 32'(addr_valid), 32'(act));
    chk("h_addr", 32'(h_addr), act ? x : 0);
    chk("v_addr", 32'(v_addr), act ? y : 0);
    chk("h_char", 32'(h_char), act ? x / CW : 0);
    chk("h_font", 32'(h_font), act ? x % CW : 0);
    chk("v_char", 32'(v_char), act ? y / CH : 0);
    chk("v_font", 32'(v_font), act ? y % CH : 0);
    chk("line_start", 32'(line_start), 32'(pclk_en && x == 0));
    chk("frame_start", 32'(frame_start), 32'(pclk_en && x == 0 && y == 0));
    if (n < PL + 1) begin
      ehs = ~HSP;
      evs = ~VSP;
      ev  = 1'b0;
    end else begin
      xd  = px(n - PL - 1);
      yd  = py(n - PL - 1);
      ehs = (xd >= HA + HF && xd < HA + HF + HS) ? HSP : ~HSP;
      evs = (yd >= VA + VF && yd < VA + VF + VS) ? VSP : ~VSP;
      ev  = (xd < HA) && (yd < VA);
    end
    chk("hsync", 32'(hsync), 32'(ehs));
    chk("vsync", 32'(vsync), 32'(evs));
    chk("valid", 32'(valid), 32'(ev));
    chk("rgb", 32'({vga_r, vga_g, vga_b}), ev ? 32'(src) : 0);
  endtask

  // One clock: drive at the falling edge, check, then advance the model on
  // the rising edge if that edge was an enabled, out-of-reset one.
  task automatic step(input logic en, input logic [11:0] d, input logic rn);
    @(negedge pclk);
    pclk_en  = en;
    vga_data = d;
    reset_n  = rn;
    if (!rn) n = 0;
    #1;
    check_outputs();
    @(posedge pclk);
    if (rn && en) begin
      n++;
      src = d;
    end
  endtask

  initial begin
    int k;
    int c_valid, c_hs, c_vs, c_fs, c_ls;
    logic [11:0] d;

    for (int i = 0; i < 5; i++) step(1'b1, 12'h000, 1'b0);

    for (int i = 0; i < 20; i++) step(1'b1, 12'($urandom), 1'b1);

    c_valid = 0; c_hs = 0; c_vs = 0; c_fs = 0; c_ls = 0;
    for (int i = 0; i < FRAME; i++) begin
      step(1'b1, 12'($urandom), 1'b1);
      #2;
      if (valid) c_valid++;
      if (hsync == HSP) c_hs++;
      if (vsync == VSP) c_vs++;
      if (frame_start) c_fs++;
      if (line_start) c_ls++;
    end
    chk("valid_per_frame", c_valid, HA * VA);
    chk("hsync_active_per_frame", c_hs, HS * VT);
    chk("vsync_active_per_frame", c_vs, VS * HT);
    chk("frame_start_per_frame", c_fs, 1);
    chk("line_start_per_frame", c_ls, VT);

    k = 0;
    while (!(px(n) == 0 && py(n) == 0) && k < 2 * FRAME) begin
      step(1'b1, 12'h000, 1'b1);
      k++;
    end
    chk("align_frame", 32'(px(n) == 0 && py(n) == 0), 1);
    for (int i = 0; i < 14; i++) begin
      d = (px(n) == 7 && py(n) == 0) ? 12'hABC : 12'h000;
      step(1'b1, d, 1'b1);
      #2;
      if (py(n) == 0) begin
        if (px(n) == 7) chk("lat_pixel4_rgb", 32'({vga_r, vga_g, vga_b}), 0);
        if (px(n) == 8) begin
          chk("lat_pixel5_rgb", 32'({vga_r, vga_g, vga_b}), 32'h0ABC);
          chk("lat_pixel5_valid", 32'(valid), 1);
          chk("x8_h_char", 32'(h_char), 0);
          chk("x8_h_font", 32'(h_font), 8);
        end
        if (px(n) == 9) begin
          chk("lat_pixel6_rgb", 32'({vga_r, vga_g, vga_b}), 0);
          chk("x9_h_char", 32'(h_char), 1);
          chk("x9_h_font", 32'(h_font), 0);
        end
      end
    end

    for (int i = 0; i < 2 * FRAME; i++)
      step(1'($urandom_range(3) == 0), 12'($urandom), 1'b1);

    k = 0;
    while (!(px(n) == 30 && py(n) == 10) && k < 8 * FRAME) begin
      step(1'($urandom_range(1)), 12'($urandom), 1'b1);
      k++;
    end
    chk("reach_mid_frame", 32'(px(n) == 30 && py(n) == 10), 1);
    for (int i = 0; i < 3; i++) step(1'($urandom_range(1)), 12'($urandom), 1'b0);
    for (int i = 0; i < 300; i++) step(1'b1, 12'($urandom), 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_char_timing.md
# vga_char_timing

Parametrised VGA timing and character-cell generator: the next generation of the team's VGA controller. It produces sync, pixel and character/font coordinates for any mode set by parameters. Sync, valid and colour outputs are delayed to match a configurable-latency pixel fetch path, such as a character RAM followed by a font ROM. It sits between the pixel-clock domain and the display pins, feeding the text-mode renderer.

## Interface

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync pulse width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BP, 33, vertical back porch (lines)
- HSYNC_POL, 0, active level of hsync
- VSYNC_POL, 0, active level of vsync
- CHAR_W, 9, character cell width (pixels, ≥2)
- CHAR_H, 16, character cell height (lines, ≥2)
- PIPE_LAT, 2, enabled cycles from address out to vga_data valid (0..4)
- ADDR_W, 10, width of h_addr/v_addr

Ports:
- pclk  in  1  pixel clock; all state on rising edge
- reset_n  in  1  asynchronous, active-low reset
- pclk_en  in  1  advance enable; when low, all state holds
- vga_data  in  12  {R,G,B} 4 bits each, for the pixel addressed PIPE_LAT enabled cycles earlier
- h_addr, v_addr  out  ADDR_W  active pixel coordinate; 0 outside active area
- h_char  out  7  character column; v_char  out  5  character row
- h_font  out  4  pixel within cell; v_font  out  4  line within cell
- addr_valid  out  1  current address is inside the active area
- line_start  out  1  one-cycle pulse on the first pixel of each line
- frame_start  out  1  one-cycle pulse on pixel (0,0)
- hsync, vsync  out  1  delayed syncs
- valid  out  1  delayed active flag
- vga_r, vga_g, vga_b  out  4  colour, forced to 0 when not valid

## Operation

- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL analogous.
- Counter x_cnt runs 0..H_TOTAL-1, then wraps to 0. y_cnt increments on an x wrap and wraps after V_TOTAL-1. Line order is active, front porch, sync, back porch.
- Address stage (registered):
  - addr_valid = x_cnt<H_ACTIVE && y_cnt<V_ACTIVE.
  - h_addr = x_cnt and v_addr = y_cnt while active, else 0.
- Character counters are incremental; no divider is used.
  - h_font counts 0..CHAR_W-1. On wrap to 0, h_char increments.
  - h_font and h_char reset to 0 at x_cnt=0.
  - v_font, v_char behave the same per line, resetting at y_cnt=0.
  - A partial last cell is allowed: at 640/9, x=639 gives h_char=71, h_font=0.
  - Char/font outputs are held at 0 outside the active area.
- Raw sync: hsync active when H_ACTIVE+H_FP ≤ x_cnt < H_ACTIVE+H_FP+H_SYNC. vsync uses the vertical equivalents.
- Delay line: raw hsync, raw vsync and addr_valid pass through a PIPE_LAT-deep shift register that advances only when pclk_en=1.
- Output register: captures the delayed flags and vga_data (zeroed when the delayed valid is 0) into hsync/vsync/valid/vga_r/g/b.
- pclk_en=0 freezes counters, delay line and output registers. line_start and frame_start read 0 while frozen.

## Timing

- Reset (async assert, synchronous release on the next edge). All outputs take these values:
  - Counters, addresses and char/font: 0.
  - addr_valid = 1, frame_start = 1, line_start = 1.
  - valid = 0, RGB = 0.
  - Delay-line flags hold the inactive sync level.
  - hsync = ~HSYNC_POL, vsync = ~VSYNC_POL.
- The first enabled edge after reset release advances to x=1.
- Video latency: addr/flag for pixel P appear at enabled cycle t. hsync/vsync/valid/RGB for P appear at t+PIPE_LAT+1, and vga_data is sampled at that edge.
- Simultaneous x and y wrap (x=H_TOTAL-1, y=V_TOTAL-1) goes to (0,0) with frame_start=1 and line_start=1.
- Reset mid-frame discards the delay-line contents; no partial pixels are emitted.

## Test plan

- Reset with defaults, reset_n low 5 cycles -> hsync=vsync=1, valid=0, RGB=0, h_addr=v_addr=0, frame_start=1.
- Free run one line, pclk_en=1 -> hsync low exactly 96 enabled cycles, for x in [656,751] delayed by 3. line_start period is 800 cycles.
- Full frame -> vsync low for y in [490,491]. frame_start period is 420000 enabled cycles. valid high for 307200 cycles per frame.
- Character boundaries -> x=8: h_char=0, h_font=8. x=9: h_char=1, h_font=0. y=16: v_char=1, v_font=0. x=639: h_char=71.
- Latency: drive vga_data=12'hABC only on the cycle 2 enabled cycles after h_addr=5, v_addr=0 -> vga_r/g/b = A/B/C exactly one cycle later, aligned with valid. Pixel 4 and pixel 6 output 0.
- Stall and reset: toggle pclk_en 1-in-4 -> all periods ×4 and outputs frozen when low. Assert reset_n at x=300, y=200 -> immediate reset values, restart at (0,0).
